// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bundle: datapath redirect/stall/instruction path plus the instruction-memory request/ack pair.
// master = fetch queue; slave = surrounding datapath and memory.
interface fetch_prefetch_queue_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          redirect;
  logic [15:0]   redirect_pc;
  logic          stall;
  logic [15:0]   inst_out;
  logic [15:0]   inst_pc;
  logic          inst_valid;
  logic          imem_req;
  logic [15:0]   imem_addr;
  logic          imem_ack;
  logic [15:0]   imem_rdata;
  logic [CW-1:0] q_count;

  modport master (
    input  redirect, redirect_pc, stall, imem_ack, imem_rdata,
    output inst_out, inst_pc, inst_valid, imem_req, imem_addr, q_count
  );

  modport slave (
    output redirect, redirect_pc, stall, imem_ack, imem_rdata,
    input  inst_out, inst_pc, inst_valid, imem_req, imem_addr, q_count
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Prefetch queue: first instruction 2 cycles after reset with zero-wait memory, then 1/cycle.
// Stall holds the head; no request is issued while the queue would be full, so pushes are never lost.
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst,
  fetch_prefetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] pc;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] q_count, q_count_next;
  state_t        state, state_next;
  logic [15:0]   fetch_pc, fetch_pc_next;
  logic [15:0]   pending_pc, pending_pc_next;
  logic          push, pop, valid, req;

  assign valid = (q_count != '0) && !bus.redirect;
  assign pop   = valid && !bus.stall;
  assign push  = (state == REQ) && bus.imem_ack && !bus.redirect;

  always_comb begin
    q_count_next = q_count + CW'(push) - CW'(pop);
    if (bus.redirect) q_count_next = '0;
  end

  always_comb begin
    state_next      = state;
    fetch_pc_next   = fetch_pc;
    pending_pc_next = pending_pc;
    req             = 1'b0;
    case (state)
      IDLE: begin
        if (bus.redirect) fetch_pc_next = bus.redirect_pc;
        if (q_count_next < CW'(DEPTH)) state_next = REQ;
      end
      REQ: begin
        req = 1'b1;
        if (bus.imem_ack) begin
          if (!bus.redirect) begin
            fetch_pc_next = fetch_pc + 16'd1;
            state_next    = (q_count_next < CW'(DEPTH)) ? REQ : IDLE;
          end else begin
            fetch_pc_next = bus.redirect_pc;
          end
        end else if (bus.redirect) begin
          pending_pc_next = bus.redirect_pc;
          state_next      = DISCARD;
        end
      end
      DISCARD: begin
        // Address stays on the stale request until memory acks it.
        req = 1'b1;
        if (bus.imem_ack) begin
          fetch_pc_next = bus.redirect ? bus.redirect_pc : pending_pc;
          state_next    = REQ;
        end else if (bus.redirect) begin
          pending_pc_next = bus.redirect_pc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      pending_pc <= 16'h0000;
      q_count    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      state      <= state_next;
      fetch_pc   <= fetch_pc_next;
      pending_pc <= pending_pc_next;
      q_count    <= q_count_next;
      if (bus.redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{inst: bus.imem_rdata, pc: bus.imem_addr};
  end

  assign bus.inst_valid = valid;
  assign bus.inst_out   = valid ? mem[rd_ptr].inst : NOP_INST;
  assign bus.inst_pc    = valid ? mem[rd_ptr].pc : 16'h0000;
  assign bus.imem_req   = req;
  assign bus.imem_addr  = fetch_pc;
  assign bus.q_count    = q_count;
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: scripted vector table, latency/redirect/reset sequences,
// and randomized traffic against a queue-based model of the instruction stream.
module tb_fetch_prefetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [15:0] NOP   = 16'hF00D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();
  fetch_prefetch_queue_if #(.DEPTH(DEPTH)) bus2 ();

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'h0000), .NOP_INST(NOP)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'hFFFE)) u_dut_wrap (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Memory responder: ack once a request has been held for cur_lat cycles; word = addr ^ scramble.
  int          lat       = 0;
  bit          rand_lat  = 1'b0;
  int          cur_lat   = 0;
  int          age       = 0;
  bit          req_seen  = 1'b0;
  logic [15:0] scramble  = 16'h0000;

  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        age          = 0;
        req_seen     = 1'b0;
        bus.imem_ack = 1'b0;
      end else begin
        if (req_seen && bus.imem_ack) age = 0;
        else if (req_seen)            age++;
        else                          age = 0;
        req_seen = bus.imem_req;
        if (age == 0) cur_lat = rand_lat ? int'($urandom_range(0, 3)) : lat;
        bus.imem_ack   = bus.imem_req && (age >= cur_lat);
        bus.imem_rdata = bus.imem_addr ^ scramble;
      end
    end
  end

  // Second instance: zero-wait memory returning word=addr, free running.
  logic [15:0] pcs2[$];
  logic [15:0] insts2[$];
  initial begin
    bus2.imem_ack    = 1'b0;
    bus2.imem_rdata  = 16'h0000;
    bus2.redirect    = 1'b0;
    bus2.redirect_pc = 16'h0000;
    bus2.stall       = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus2.imem_ack   = bus2.imem_req && !rst;
      bus2.imem_rdata = bus2.imem_addr;
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus2.inst_valid && pcs2.size() < 4) begin
        pcs2.push_back(bus2.inst_pc);
        insts2.push_back(bus2.inst_out);
      end
    end
  end

  task automatic step(input bit s, input bit r, input logic [15:0] rp);
    @(posedge clk);
    #1;
    bus.stall       = s;
    bus.redirect    = r;
    bus.redirect_pc = rp;
    @(negedge clk);
  endtask

  typedef struct {
    bit          stall;
    bit          redir;
    logic [15:0] rpc;
    bit          e_valid;
    logic [15:0] e_pc;
    logic [15:0] e_inst;
    int          e_q;
    bit          e_req;
    logic [15:0] e_addr;
  } vec_t;

  function automatic vec_t mk(bit s, bit r, logic [15:0] rp, bit v, logic [15:0] pc,
                              logic [15:0] inst, int q, bit req, logic [15:0] addr);
    vec_t t;
    t = '{s, r, rp, v, pc, inst, q, req, addr};
    return t;
  endfunction

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] pc;
  } ent_t;

  vec_t        tbl [25];
  ent_t        mq[$];
  logic [15:0] next_fetch;
  bit          stale, p_req, p_ack, got, s, r, exp_valid;
  logic [15:0] p_addr, rp;

  initial begin
    // Zero-wait, word=addr: stream, 10-cycle stall to full, redirect with ack, redirect under stall.
    tbl[0] = mk(0, 0, 0, 0, 0, NOP, 0, 1, 0);
    for (int i = 1; i <= 4; i++) tbl[i] = mk(i == 4, 0, 0, 1, 16'(i-1), 16'(i-1), 1, 1, 16'(i));
    tbl[5] = mk(1, 0, 0, 1, 3, 3, 2, 1, 5);
    tbl[6] = mk(1, 0, 0, 1, 3, 3, 3, 1, 6);
    for (int i = 7; i <= 13; i++) tbl[i] = mk(1, 0, 0, 1, 3, 3, 4, 0, 7);
    tbl[14] = mk(0, 0, 0, 1, 3, 3, 4, 0, 7);
    for (int i = 15; i <= 18; i++) tbl[i] = mk(0, 0, 0, 1, 16'(i-11), 16'(i-11), 3, 1, 16'(i-8));
    tbl[19] = mk(0, 1, 16'h0100, 0, 0, NOP, 3, 1, 16'd11);
    tbl[20] = mk(0, 0, 0, 0, 0, NOP, 0, 1, 16'h0100);
    tbl[21] = mk(0, 0, 0, 1, 16'h0100, 16'h0100, 1, 1, 16'h0101);
    tbl[22] = mk(1, 1, 16'h0200, 0, 0, NOP, 1, 1, 16'h0102);
    tbl[23] = mk(0, 0, 0, 0, 0, NOP, 0, 1, 16'h0200);
    tbl[24] = mk(0, 0, 0, 1, 16'h0200, 16'h0200, 1, 1, 16'h0201);

    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_req",   bus.imem_req,   0);
    check("rst_addr",  bus.imem_addr,  16'h0000);
    check("rst_valid", bus.inst_valid, 0);
    check("rst_inst",  bus.inst_out,   NOP);
    check("rst_pc",    bus.inst_pc,    16'h0000);
    check("rst_q",     bus.q_count,    0);
    check("rst_addr_wrap", bus2.imem_addr, 16'hFFFE);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].stall, tbl[i].redir, tbl[i].rpc);
      check($sformatf("tbl%0d_valid", i), bus.inst_valid, tbl[i].e_valid);
      check($sformatf("tbl%0d_pc", i),    bus.inst_pc,    tbl[i].e_pc);
      check($sformatf("tbl%0d_inst", i),  bus.inst_out,   tbl[i].e_inst);
      check($sformatf("tbl%0d_q", i),     bus.q_count,    tbl[i].e_q);
      check($sformatf("tbl%0d_req", i),   bus.imem_req,   tbl[i].e_req);
      check($sformatf("tbl%0d_addr", i),  bus.imem_addr,  tbl[i].e_addr);
    end

    // RESET_PC=FFFE instance: sequence wraps through 0.
    check("wrap_cnt", pcs2.size(), 4);
    for (int i = 0; i < 4 && i < pcs2.size(); i++) begin
      check($sformatf("wrap_pc%0d", i),   pcs2[i],   16'(16'hFFFE + i));
      check($sformatf("wrap_inst%0d", i), insts2[i], 16'(16'hFFFE + i));
    end

    // 3-cycle latency, redirect while request to 0x0005 is outstanding.
    @(negedge clk); rst = 1'b1; lat = 3;
    bus.redirect = 1'b1; bus.redirect_pc = 16'h0005;
    @(negedge clk); rst = 1'b0;
    step(0, 0, 0);
    check("lat_c1_addr", bus.imem_addr, 16'h0005);
    step(0, 1, 16'h0040);
    check("lat_c2_addr",  bus.imem_addr,  16'h0005);
    check("lat_c2_valid", bus.inst_valid, 0);
    step(0, 0, 0);
    check("lat_c3_hold", {bus.imem_req, bus.imem_addr}, {1'b1, 16'h0005});
    step(0, 0, 0);
    check("lat_c4_ack", {bus.imem_ack, bus.imem_addr}, {1'b1, 16'h0005});
    step(0, 0, 0);
    check("lat_c5_addr", bus.imem_addr, 16'h0040);
    check("lat_c5_q",    bus.q_count,   0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1, 0, 0);
      got = bus.inst_valid;
    end
    check("lat_got_valid", got, 1);
    check("lat_first_pc",   bus.inst_pc,  16'h0040);
    check("lat_first_inst", bus.inst_out, 16'h0040);

    // Async reset mid-transaction: request to 0x41 outstanding, one entry held by stall.
    step(1, 0, 0);
    check("arst_pre_q",   bus.q_count,  1);
    check("arst_pre_req", bus.imem_req, 1);
    @(posedge clk); #3; rst = 1'b1; #1;
    check("arst_req",   bus.imem_req,   0);
    check("arst_valid", bus.inst_valid, 0);
    check("arst_inst",  bus.inst_out,   NOP);
    check("arst_q",     bus.q_count,    0);
    check("arst_addr",  bus.imem_addr,  16'h0000);
    @(negedge clk); rst = 1'b0; lat = 0; bus.stall = 1'b0;
    step(0, 0, 0);
    check("arst_restart", {bus.imem_req, bus.imem_addr}, {1'b1, 16'h0000});

    // Randomized traffic against the stream model.
    @(negedge clk); rst = 1'b1; rand_lat = 1'b1; scramble = 16'h5A3C;
    bus.stall = 1'b0; bus.redirect = 1'b0;
    @(negedge clk); rst = 1'b0;
    mq.delete(); next_fetch = 16'h0000; stale = 1'b0; p_req = 1'b0; p_ack = 1'b0; p_addr = 16'h0000;
    for (int c = 0; c < 1500; c++) begin
      s  = ($urandom_range(0, 9) < 3);
      r  = ($urandom_range(0, 15) == 0);
      rp = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom);
      step(s, r, rp);
      exp_valid = (mq.size() != 0) && !r;
      check("rnd_valid", bus.inst_valid, exp_valid);
      check("rnd_q",     bus.q_count,    mq.size());
      if (exp_valid) begin
        check("rnd_pc",   bus.inst_pc,  mq[0].pc);
        check("rnd_inst", bus.inst_out, mq[0].inst);
      end else begin
        check("rnd_nop", bus.inst_out, NOP);
      end
      if (p_req && !p_ack) check("rnd_hold", {bus.imem_req, bus.imem_addr}, {1'b1, p_addr});
      if (r) begin
        mq.delete();
        next_fetch = rp;
        if (bus.imem_req) stale = !bus.imem_ack;
      end else begin
        if (mq.size() != 0 && !s) void'(mq.pop_front());
        if (bus.imem_req && bus.imem_ack) begin
          if (stale) stale = 1'b0;
          else begin
            check("rnd_addr", bus.imem_addr, next_fetch);
            mq.push_back('{inst: next_fetch ^ scramble, pc: next_fetch});
            next_fetch = next_fetch + 16'd1;
            check("rnd_no_overflow", mq.size() <= DEPTH, 1);
          end
        end
      end
      p_req  = bus.imem_req;
      p_ack  = bus.imem_ack;
      p_addr = bus.imem_addr;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
